// File: rtl/button_grid_renderer.sv
// Two-stage keypad pixel renderer: button lookup, glyph fetch, press flash and hover background.
// Optional feature macro: HOVER_HIGHLIGHT_EN (compiles in the hover background when defined).
module button_grid_renderer #(
   parameter int          ROWS        = 3,
   parameter int          COLS        = 6,
   parameter int          CELL_W      = 16,
   parameter int          CELL_H      = 16,
   parameter int          GLYPH_W     = 5,
   parameter int          GLYPH_H     = 8,
   parameter int          GLYPH_X0    = 5,
   parameter int          GLYPH_Y0    = 3,
   parameter int          HOLD_FRAMES = 8,
   parameter logic [11:0] FG_COLOR    = 12'hFFF,
   parameter logic [11:0] BG_COLOR    = 12'h000,
   parameter logic [11:0] HOVER_BG    = 12'h008,
   parameter logic [11:0] PRESS_BG    = 12'h0F0,
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
   localparam int IW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1,
   localparam int XW = (CELL_W > 1) ? $clog2(CELL_W) : 1,
   localparam int YW = (CELL_H > 1) ? $clog2(CELL_H) : 1,
   localparam int LW = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               pix_valid,
   input  logic [RW-1:0]      cell_row,
   input  logic [CW-1:0]      cell_col,
   input  logic [XW-1:0]      pix_x,
   input  logic [YW-1:0]      pix_y,
   output logic [IW-1:0]      glyph_idx,
   output logic [LW-1:0]      glyph_line,
   input  logic [GLYPH_W-1:0] glyph_bits,
   input  logic               frame_start,
   input  logic               press_valid,
   input  logic [RW-1:0]      press_row,
   input  logic [CW-1:0]      press_col,
   input  logic               hover_valid,
   input  logic [RW-1:0]      hover_row,
   input  logic [CW-1:0]      hover_col,
   output logic [11:0]        rgb,
   output logic               rgb_valid,
   output logic [IW-1:0]      pressed_idx,
   output logic               pressed_active
);

   localparam int BCW  = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
   localparam int CNTW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

   logic [31:0]     row_w, col_w, px_w, py_w;
   logic            in_grid_d, in_glyph_d;
   logic [IW-1:0]   glyph_idx_d;
   logic [LW-1:0]   glyph_line_d;
   logic [BCW-1:0]  bitcol_d;

   logic            v1_q, in_grid_q, in_glyph_q;
   logic [IW-1:0]   glyph_idx_q;
   logic [LW-1:0]   glyph_line_q;
   logic [BCW-1:0]  bitcol_q;

   logic            press_ok;
   logic [IW-1:0]   press_idx;
   logic [IW-1:0]   pressed_idx_q, pressed_idx_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            pressed_active_q, pressed_active_d;

   logic [(1<<BCW)-1:0] glyph_rev;
   logic            hover_hit;
   logic            pixel_on;
   logic [11:0]     bg_color;
   logic [11:0]     rgb_q, rgb_d;
   logic            rgb_valid_q, rgb_valid_d;

   assign row_w = 32'(cell_row);
   assign col_w = 32'(cell_col);
   assign px_w  = 32'(pix_x);
   assign py_w  = 32'(pix_y);

   always_comb begin
      in_grid_d    = (row_w < ROWS) && (col_w < COLS);
      glyph_idx_d  = IW'(row_w * COLS + col_w);
      glyph_line_d = LW'(py_w - 32'(GLYPH_Y0));
      bitcol_d     = BCW'(px_w - 32'(GLYPH_X0));
      in_glyph_d   = in_grid_d
                  && (px_w >= GLYPH_X0) && (px_w < GLYPH_X0 + GLYPH_W)
                  && (py_w >= GLYPH_Y0) && (py_w < GLYPH_Y0 + GLYPH_H);
   end

   // A press takes priority over a same-cycle frame tick, so the hold restarts at full length.
   always_comb begin
      press_ok         = (32'(press_row) < ROWS) && (32'(press_col) < COLS);
      press_idx        = IW'(32'(press_row) * COLS + 32'(press_col));
      pressed_idx_d    = pressed_idx_q;
      cnt_d            = cnt_q;
      pressed_active_d = pressed_active_q;
      if (press_valid && press_ok) begin
         pressed_idx_d    = press_idx;
         cnt_d            = CNTW'(HOLD_FRAMES);
         pressed_active_d = (HOLD_FRAMES != 0);
      end else if (frame_start && (cnt_q != '0)) begin
         cnt_d            = cnt_q - CNTW'(1);
         pressed_active_d = (cnt_q != CNTW'(1));
      end
   end

   // Bit-reversed, zero-padded glyph line so bitcol indexes left-to-right without range issues.
   generate
      for (genvar gi = 0; gi < (1 << BCW); gi++) begin : g_rev
         if (gi < GLYPH_W) begin : g_bit
            assign glyph_rev[gi] = glyph_bits[GLYPH_W-1-gi];
         end else begin : g_pad
            assign glyph_rev[gi] = 1'b0;
         end
      end
   endgenerate

`ifdef HOVER_HIGHLIGHT_EN
   logic [IW-1:0] hover_idx;
   assign hover_idx = IW'(32'(hover_row) * COLS + 32'(hover_col));
   assign hover_hit = hover_valid && (glyph_idx_q == hover_idx);
`else
   logic unused_hover;
   assign unused_hover = ^{hover_valid, hover_row, hover_col};
   assign hover_hit    = 1'b0;
`endif

   always_comb begin
      bg_color = BG_COLOR;
      if (pressed_active_q && (glyph_idx_q == pressed_idx_q)) begin
         bg_color = PRESS_BG;
      end else if (hover_hit) begin
         bg_color = HOVER_BG;
      end
      pixel_on    = in_glyph_q && glyph_rev[bitcol_q];
      rgb_valid_d = v1_q;
      rgb_d       = 12'h000;
      if (v1_q && in_grid_q) begin
         rgb_d = pixel_on ? FG_COLOR : bg_color;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         v1_q             <= 1'b0;
         in_grid_q        <= 1'b0;
         in_glyph_q       <= 1'b0;
         glyph_idx_q      <= '0;
         glyph_line_q     <= '0;
         bitcol_q         <= '0;
         pressed_idx_q    <= '0;
         cnt_q            <= '0;
         pressed_active_q <= 1'b0;
         rgb_q            <= 12'h000;
         rgb_valid_q      <= 1'b0;
      end else begin
         v1_q             <= pix_valid;
         in_grid_q        <= in_grid_d;
         in_glyph_q       <= in_glyph_d;
         glyph_idx_q      <= glyph_idx_d;
         glyph_line_q     <= glyph_line_d;
         bitcol_q         <= bitcol_d;
         pressed_idx_q    <= pressed_idx_d;
         cnt_q            <= cnt_d;
         pressed_active_q <= pressed_active_d;
         rgb_q            <= rgb_d;
         rgb_valid_q      <= rgb_valid_d;
      end
   end

   assign glyph_idx      = glyph_idx_q;
   assign glyph_line     = glyph_line_q;
   assign rgb            = rgb_q;
   assign rgb_valid      = rgb_valid_q;
   assign pressed_idx    = pressed_idx_q;
   assign pressed_active = pressed_active_q;

endmodule

// File: tb/tb_button_grid_renderer.sv
// Bench for button_grid_renderer: reset, table vectors, press/hover/reset sequences, random vs model.
module tb_button_grid_renderer;

   localparam int HOLD = 8;
`ifdef HOVER_HIGHLIGHT_EN
   localparam bit HOVER_ON = 1'b1;
`else
   localparam bit HOVER_ON = 1'b0;
`endif

   logic        clk;
   logic        reset_n;
   logic        pix_valid;
   logic [1:0]  cell_row;
   logic [2:0]  cell_col;
   logic [3:0]  pix_x;
   logic [3:0]  pix_y;
   logic [4:0]  glyph_idx;
   logic [2:0]  glyph_line;
   logic [4:0]  glyph_bits;
   logic        frame_start;
   logic        press_valid;
   logic [1:0]  press_row;
   logic [2:0]  press_col;
   logic        hover_valid;
   logic [1:0]  hover_row;
   logic [2:0]  hover_col;
   logic [11:0] rgb;
   logic        rgb_valid;
   logic [4:0]  pressed_idx;
   logic        pressed_active;

   bit rom_mode;
   int total;
   int bad;

   typedef struct {
      logic        v;
      logic [1:0]  r;
      logic [2:0]  c;
      logic [3:0]  x;
      logic [3:0]  y;
      logic [11:0] exp_rgb;
   } vec_t;

   localparam int NV = 12;
   vec_t tbl[NV];

   button_grid_renderer dut (
      .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid),
      .cell_row(cell_row), .cell_col(cell_col), .pix_x(pix_x), .pix_y(pix_y),
      .glyph_idx(glyph_idx), .glyph_line(glyph_line), .glyph_bits(glyph_bits),
      .frame_start(frame_start), .press_valid(press_valid),
      .press_row(press_row), .press_col(press_col),
      .hover_valid(hover_valid), .hover_row(hover_row), .hover_col(hover_col),
      .rgb(rgb), .rgb_valid(rgb_valid),
      .pressed_idx(pressed_idx), .pressed_active(pressed_active)
   );

   function automatic logic [4:0] rom_hash(input logic [4:0] idx, input logic [2:0] line);
      logic [7:0] t;
      t = 8'(idx) * 8'd29 + 8'(line) * 8'd11 + 8'd3;
      return t[6:2];
   endfunction

   // Glyph ROM: constant centre-column line for directed tests, hashed content for random.
   assign glyph_bits = rom_mode ? rom_hash(glyph_idx, glyph_line) : 5'b00100;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic press(input int r, input int c, input logic fs);
      press_row   = 2'(r);
      press_col   = 3'(c);
      press_valid = 1'b1;
      frame_start = fs;
      tick();
      press_valid = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic frames(input int n);
      for (int k = 0; k < n; k++) begin
         frame_start = 1'b1;
         tick();
         frame_start = 1'b0;
         tick();
      end
   endtask

   task automatic pixel_check(input string name, input int r, input int c, input int x,
                              input int y, input logic [11:0] exp);
      pix_valid = 1'b1;
      cell_row  = 2'(r);
      cell_col  = 3'(c);
      pix_x     = 4'(x);
      pix_y     = 4'(y);
      tick();
      pix_valid = 1'b0;
      tick();
      chk({name, "_valid"}, 32'(rgb_valid), 32'd1);
      chk(name, 32'(rgb), 32'(exp));
      $display("%s: cell(%0d,%0d) pix(%0d,%0d) rgb=%h", name, r, c, x, y, rgb);
   endtask

   // Spec-level colour of one pixel given the press and hover state seen by the output stage.
   function automatic logic [11:0] exp_colour(input int r, input int c, input int x, input int y,
                                              input bit act, input int pidx,
                                              input bit hv, input int hr, input int hc);
      int          idx, gx, gy;
      logic [11:0] bg;
      logic [4:0]  bits;
      if (r >= 3 || c >= 6) return 12'h000;
      idx = r * 6 + c;
      bg  = 12'h000;
      if (act && idx == pidx) bg = 12'h0F0;
      else if (HOVER_ON && hv && idx == hr * 6 + hc) bg = 12'h008;
      gx = x - 5;
      gy = y - 3;
      if (gx >= 0 && gx < 5 && gy >= 0 && gy < 8) begin
         bits = rom_hash(5'(idx), 3'(gy));
         if (bits[4 - gx]) return 12'hFFF;
      end
      return bg;
   endfunction

   int          m_cnt, m_idx;
   bit          s1_v;
   int          s1_r, s1_c, s1_x, s1_y;
   logic        exp_v;
   logic [11:0] exp_rgb;

   initial begin
      total = 0;
      bad   = 0;
      tbl[0]  = '{1'b1, 2'd0, 3'd0, 4'd7, 4'd5,  12'hFFF};
      tbl[1]  = '{1'b1, 2'd0, 3'd0, 4'd5, 4'd5,  12'h000};
      tbl[2]  = '{1'b1, 2'd3, 3'd0, 4'd7, 4'd5,  12'h000};
      tbl[3]  = '{1'b1, 2'd0, 3'd6, 4'd7, 4'd5,  12'h000};
      tbl[4]  = '{1'b1, 2'd2, 3'd5, 4'd7, 4'd3,  12'hFFF};
      tbl[5]  = '{1'b1, 2'd2, 3'd5, 4'd7, 4'd10, 12'hFFF};
      tbl[6]  = '{1'b1, 2'd2, 3'd5, 4'd7, 4'd11, 12'h000};
      tbl[7]  = '{1'b1, 2'd1, 3'd1, 4'd7, 4'd2,  12'h000};
      tbl[8]  = '{1'b1, 2'd1, 3'd1, 4'd4, 4'd5,  12'h000};
      tbl[9]  = '{1'b0, 2'd1, 3'd1, 4'd7, 4'd5,  12'h000};
      tbl[10] = '{1'b1, 2'd1, 3'd3, 4'd7, 4'd7,  12'hFFF};
      tbl[11] = '{1'b1, 2'd2, 3'd5, 4'd6, 4'd5,  12'h000};

      rom_mode    = 1'b0;
      reset_n     = 1'b0;
      pix_valid   = 1'b1;
      cell_row    = 2'd0;
      cell_col    = 3'd0;
      pix_x       = 4'd7;
      pix_y       = 4'd5;
      frame_start = 1'b0;
      press_valid = 1'b0;
      press_row   = 2'd0;
      press_col   = 3'd0;
      hover_valid = 1'b0;
      hover_row   = 2'd0;
      hover_col   = 3'd0;

      // Reset state and first-pixel latency
      repeat (3) tick();
      chk("rst_rgb", 32'(rgb), 32'h0);
      chk("rst_valid", 32'(rgb_valid), 32'd0);
      chk("rst_idx", 32'(glyph_idx), 32'd0);
      chk("rst_line", 32'(glyph_line), 32'd0);
      chk("rst_pidx", 32'(pressed_idx), 32'd0);
      chk("rst_pact", 32'(pressed_active), 32'd0);
      reset_n = 1'b1;
      tick();
      chk("lat1_valid", 32'(rgb_valid), 32'd0);
      chk("lat1_line", 32'(glyph_line), 32'd2);
      pix_x = 4'd5;
      tick();
      chk("lat2_valid", 32'(rgb_valid), 32'd1);
      chk("lat2_rgb", 32'(rgb), 32'hFFF);
      pix_valid = 1'b0;
      tick();
      chk("lat3_valid", 32'(rgb_valid), 32'd1);
      chk("lat3_rgb", 32'(rgb), 32'h000);
      tick();
      chk("lat4_valid", 32'(rgb_valid), 32'd0);
      $display("reset sweep: checks so far=%0d", total);

      // Streamed table vectors, one per clock
      for (int i = 0; i <= NV; i++) begin
         if (i < NV) begin
            pix_valid = tbl[i].v;
            cell_row  = tbl[i].r;
            cell_col  = tbl[i].c;
            pix_x     = tbl[i].x;
            pix_y     = tbl[i].y;
         end else begin
            pix_valid = 1'b0;
         end
         tick();
         if (i < NV && tbl[i].v && tbl[i].r < 2'd3 && tbl[i].c < 3'd6) begin
            chk("tbl_idx", 32'(glyph_idx), 32'(tbl[i].r) * 6 + 32'(tbl[i].c));
            if (tbl[i].x >= 4'd5 && tbl[i].x < 4'd10 && tbl[i].y >= 4'd3 && tbl[i].y < 4'd11)
               chk("tbl_line", 32'(glyph_line), 32'(tbl[i].y) - 3);
         end
         if (i >= 1) begin
            chk("tbl_valid", 32'(rgb_valid), 32'(tbl[i-1].v));
            chk("tbl_rgb", 32'(rgb), 32'(tbl[i-1].exp_rgb));
            $display("vec %0d: cell(%0d,%0d) pix(%0d,%0d) v=%0b rgb=%h", i - 1, tbl[i-1].r,
                     tbl[i-1].c, tbl[i-1].x, tbl[i-1].y, rgb_valid, rgb);
         end
      end

      // Press together with a pixel of that button: visible on the very next output
      press_row   = 2'd1;
      press_col   = 3'd2;
      press_valid = 1'b1;
      pix_valid   = 1'b1;
      cell_row    = 2'd1;
      cell_col    = 3'd2;
      pix_x       = 4'd0;
      pix_y       = 4'd0;
      tick();
      press_valid = 1'b0;
      pix_valid   = 1'b0;
      chk("press_idx", 32'(pressed_idx), 32'd8);
      chk("press_act", 32'(pressed_active), 32'd1);
      tick();
      chk("press_bg_valid", 32'(rgb_valid), 32'd1);
      chk("press_bg", 32'(rgb), 32'h0F0);
      $display("press (1,2): idx=%0d rgb=%h", pressed_idx, rgb);
      pixel_check("press_glyph", 1, 2, 7, 5, 12'hFFF);
      pixel_check("press_other", 1, 3, 0, 0, 12'h000);
      frames(7);
      chk("hold7_act", 32'(pressed_active), 32'd1);
      frames(1);
      chk("hold8_act", 32'(pressed_active), 32'd0);
      chk("hold8_idx", 32'(pressed_idx), 32'd8);
      pixel_check("press_expired", 1, 2, 0, 0, 12'h000);

      // Press beats hover; hover alone depends on the build
      hover_valid = 1'b1;
      hover_row   = 2'd0;
      hover_col   = 3'd1;
      press(0, 1, 1'b0);
      pixel_check("press_over_hover", 0, 1, 0, 0, 12'h0F0);
      frames(8);
      pixel_check("hover_only", 0, 1, 0, 0, HOVER_ON ? 12'h008 : 12'h000);
      pixel_check("hover_other", 0, 2, 0, 0, 12'h000);
      pixel_check("hover_glyph", 0, 1, 7, 4, 12'hFFF);
      hover_valid = 1'b0;
      pixel_check("hover_off", 0, 1, 0, 0, 12'h000);

      // Press and frame tick together at cnt=1: full restart, no decrement
      press(2, 0, 1'b0);
      frames(7);
      chk("same_pre_act", 32'(pressed_active), 32'd1);
      press(2, 0, 1'b1);
      chk("same_act", 32'(pressed_active), 32'd1);
      chk("same_idx", 32'(pressed_idx), 32'd12);
      frames(7);
      chk("same_hold7", 32'(pressed_active), 32'd1);
      frames(1);
      chk("same_hold8", 32'(pressed_active), 32'd0);
      $display("press+frame same cycle: act=%0b", pressed_active);

      // Out-of-range presses are ignored
      press(3, 0, 1'b0);
      chk("oor_row_idx", 32'(pressed_idx), 32'd12);
      chk("oor_row_act", 32'(pressed_active), 32'd0);
      press(0, 6, 1'b0);
      chk("oor_col_idx", 32'(pressed_idx), 32'd12);
      chk("oor_col_act", 32'(pressed_active), 32'd0);
      $display("out-of-range presses: idx=%0d act=%0b", pressed_idx, pressed_active);

      // Reset mid-stream with a highlight active and pixels in flight
      press(1, 1, 1'b0);
      pix_valid = 1'b1;
      cell_row  = 2'd1;
      cell_col  = 3'd1;
      pix_x     = 4'd0;
      pix_y     = 4'd0;
      tick();
      tick();
      chk("mid_pre_rgb", 32'(rgb), 32'h0F0);
      reset_n = 1'b0;
      tick();
      chk("mid_valid", 32'(rgb_valid), 32'd0);
      chk("mid_rgb", 32'(rgb), 32'h0);
      chk("mid_act", 32'(pressed_active), 32'd0);
      chk("mid_pidx", 32'(pressed_idx), 32'd0);
      reset_n = 1'b1;
      tick();
      chk("mid_rel_valid", 32'(rgb_valid), 32'd0);
      tick();
      chk("mid_next_valid", 32'(rgb_valid), 32'd1);
      chk("mid_next_rgb", 32'(rgb), 32'h000);
      $display("mid-stream reset: valid=%0b act=%0b", rgb_valid, pressed_active);
      pix_valid = 1'b0;

      // Random traffic against the reference model
      rom_mode = 1'b1;
      m_cnt    = 0;
      m_idx    = 0;
      s1_v     = 1'b0;
      s1_r     = 0;
      s1_c     = 0;
      s1_x     = 0;
      s1_y     = 0;
      for (int n = 0; n < 2000; n++) begin
         reset_n     = (n == 0) ? 1'b0 : ($urandom_range(0, 249) != 0);
         pix_valid   = ($urandom_range(0, 4) != 0);
         cell_row    = 2'($urandom_range(0, 3));
         cell_col    = 3'($urandom_range(0, 7));
         pix_x       = 4'($urandom_range(0, 15));
         pix_y       = 4'($urandom_range(0, 15));
         press_valid = ($urandom_range(0, 24) == 0);
         press_row   = 2'($urandom_range(0, 3));
         press_col   = 3'($urandom_range(0, 7));
         frame_start = ($urandom_range(0, 3) == 0);
         hover_valid = 1'($urandom_range(0, 1));
         hover_row   = 2'($urandom_range(0, 2));
         hover_col   = 3'($urandom_range(0, 5));
         if (!reset_n) begin
            exp_v   = 1'b0;
            exp_rgb = 12'h000;
            s1_v    = 1'b0;
            m_cnt   = 0;
            m_idx   = 0;
         end else begin
            exp_v   = s1_v;
            exp_rgb = s1_v ? exp_colour(s1_r, s1_c, s1_x, s1_y, m_cnt > 0, m_idx,
                                        hover_valid, int'(hover_row), int'(hover_col)) : 12'h000;
            if (press_valid && press_row < 2'd3 && press_col < 3'd6) begin
               m_idx = int'(press_row) * 6 + int'(press_col);
               m_cnt = HOLD;
            end else if (frame_start && m_cnt > 0) begin
               m_cnt--;
            end
            s1_v = pix_valid;
            s1_r = int'(cell_row);
            s1_c = int'(cell_col);
            s1_x = int'(pix_x);
            s1_y = int'(pix_y);
         end
         tick();
         chk("rnd_valid", 32'(rgb_valid), 32'(exp_v));
         chk("rnd_rgb", 32'(rgb), 32'(exp_rgb));
         chk("rnd_act", 32'(pressed_active), (m_cnt > 0) ? 32'd1 : 32'd0);
         chk("rnd_pidx", 32'(pressed_idx), 32'(m_idx));
      end
      $display("random phase: 2000 cycles");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
